// File: rtl/seg_capture_pkg.sv
// ----------------------------------------------------------------------------
// seg_capture_pkg -- shared types, FSM encoding and segment patterns
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seg_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

    // Active-low patterns, bit0 = segment a .. bit6 = segment g
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic one_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] low_pos(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
// ----------------------------------------------------------------------------
// seg_decode -- combinational 7-segment pattern to BCD digit with invalid flag
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg_decode
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output digit_t     digit,
    output logic       invalid
);

    always_comb begin
        digit   = 4'd0;
        invalid = 1'b0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_capture.sv
// ----------------------------------------------------------------------------
// seg_capture -- captures a multiplexed 4-digit 7-segment scan into BCD.
// Define SEG_CAPTURE_SYNC_EN for a two-flop input synchronizer. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [6:0]  seven_seg_in,
    input  logic [3:0]  anode_in,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        digit_err,
    output logic [3:0]  seen
);

    localparam logic [7:0] STABLE_COUNT = 8'(STABLE_CYCLES);

    logic [10:0] pair_in;

`ifdef SEG_CAPTURE_SYNC_EN
    logic [10:0] sync1_q, sync2_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {anode_in, seven_seg_in};
            sync2_q <= sync1_q;
        end
    end

    assign pair_in = sync2_q;
`else
    assign pair_in = {anode_in, seven_seg_in};
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] pair_q, pair_d, prev_q, prev_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] shadow_q, shadow_d, value_q, value_d;
    logic        value_valid_q, value_valid_d;
    logic        digit_err_q, digit_err_d;

    digit_t      dec_digit;
    logic        dec_invalid;
    logic        fire;
    logic [1:0]  pos;

    seg_decode u_seg_decode (
        .seg     (pair_q[6:0]),
        .digit   (dec_digit),
        .invalid (dec_invalid)
    );

    always_comb begin
        pair_d        = pair_in;
        prev_d        = pair_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        seen_d        = seen_q;
        shadow_d      = shadow_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        digit_err_d   = 1'b0;
        fire          = 1'b0;
        pos           = low_pos(pair_q[10:7]);

        if (seen_q == 4'hF) begin
            value_d       = shadow_q;
            value_valid_d = 1'b1;
            seen_d        = 4'h0;
        end

        // A changed pair restarts the count on the new pair in the same cycle
        if (!one_low(pair_q[10:7])) begin
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
        end else if (state_q == ST_WAIT || pair_q != prev_q) begin
            state_d = ST_COUNT;
            cnt_d   = 8'd1;
            fire    = (STABLE_COUNT == 8'd1);
        end else if (state_q == ST_COUNT) begin
            cnt_d = cnt_q + 8'd1;
            fire  = (cnt_d == STABLE_COUNT);
        end

        if (fire) begin
            state_d = ST_HELD;
            if (dec_invalid) begin
                digit_err_d = 1'b1;
                seen_d      = 4'h0;
            end else begin
                shadow_d[{pos, 2'b00} +: 4] = dec_digit;
                seen_d[pos]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_WAIT;
            cnt_q         <= 8'd0;
            pair_q        <= '1;
            prev_q        <= '1;
            seen_q        <= 4'h0;
            shadow_q      <= 16'h0000;
            value_q       <= 16'h0000;
            value_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pair_q        <= pair_d;
            prev_q        <= prev_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            digit_err_q   <= digit_err_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign digit_err   = digit_err_q;
    assign seen        = seen_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_capture.sv
// ----------------------------------------------------------------------------
// tb_seg_capture -- self-checking bench for seg_capture (run-length reference model)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg_capture;

    localparam int S = 4;
`ifdef SEG_CAPTURE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seven_seg_in = 7'h7F;
    logic [3:0]  anode_in = 4'hF;
    logic [15:0] value;
    logic        value_valid;
    logic        digit_err;
    logic [3:0]  seen;

    seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .seven_seg_in (seven_seg_in),
        .anode_in     (anode_in),
        .value        (value),
        .value_valid  (value_valid),
        .digit_err    (digit_err),
        .seen         (seen)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int vv_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int vv_cyc = -1;

    logic [6:0] pats [10];

    // Reference model: a digit is decoded when a valid pair has been
    // sampled for exactly S consecutive cycles.
    logic [10:0] hist [$];
    logic [10:0] m_last;
    int          m_run;
    logic [15:0] m_shadow, m_value;
    logic [3:0]  m_seen;
    logic        m_vv, m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= D; i++) hist.push_back(11'h7FF);
        m_last = 11'h7FF;
        m_run = 0;
        m_shadow = 16'h0;
        m_value = 16'h0;
        m_seen = 4'h0;
        m_vv = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [10:0] in_pair);
        logic [10:0] s;
        logic        ok;
        int          k, d;
        hist.push_back(in_pair);
        s = hist.pop_front();
        ok = ($countones(~s[10:7]) == 1);
        if (ok && s == m_last) m_run++;
        else m_run = ok ? 1 : 0;
        m_last = s;
        m_vv = 1'b0;
        m_err = 1'b0;
        if (m_seen == 4'hF) begin
            m_value = m_shadow;
            m_vv = 1'b1;
            m_seen = 4'h0;
        end
        if (m_run == S) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (!s[7+i]) k = i;
            d = -1;
            for (int i = 0; i < 10; i++) if (pats[i] == s[6:0]) d = i;
            if (d < 0) begin
                m_err = 1'b1;
                m_seen = 4'h0;
            end else begin
                m_shadow[4*k +: 4] = 4'(d);
                m_seen[k] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        if (!reset_n) model_reset();
        else model_edge({anode_in, seven_seg_in});
        #1;
        cyc++;
        chk("value", value, m_value);
        chk("value_valid", {15'd0, value_valid}, {15'd0, m_vv});
        chk("digit_err", {15'd0, digit_err}, {15'd0, m_err});
        chk("seen", {12'd0, seen}, {12'd0, m_seen});
        if (value_valid) begin
            vv_cnt++;
            vv_cyc = cyc;
        end
        if (digit_err) err_cnt++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        anode_in = an;
        seven_seg_in = sg;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          n;
        logic [3:0]  exp_seen;
        logic [15:0] exp_value;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int start;
        logic [15:0] exp_v;
        logic [3:0] dg [4];
        logic [3:0] an;
        logic [6:0] sg;

        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        tbl[0] = '{4'b1110, 7'b0010000, 8, 4'b0001, 16'h0000};
        tbl[1] = '{4'b1110, 7'b0100100, 8, 4'b0001, 16'h0000};
        tbl[2] = '{4'b1101, 7'b0010010, 8, 4'b0011, 16'h0000};
        tbl[3] = '{4'b1001, 7'b1111001, 8, 4'b0011, 16'h0000};
        tbl[4] = '{4'b1011, 7'b0000000, 8, 4'b0111, 16'h0000};
        tbl[5] = '{4'b0111, 7'b1000000, 8, 4'b0000, 16'h0852};
        tbl[6] = '{4'b1111, 7'b0110000, 8, 4'b0000, 16'h0852};
        tbl[7] = '{4'b1110, 7'b0001000, 8, 4'b0000, 16'h0852};

        model_reset();
        do_reset();
        chk("reset_value", value, 16'h0000);
        chk("reset_seen", {12'd0, seen}, 16'h0000);

        // Full scan 0,1,2,3
        vv_cnt = 0;
        hold(4'b1110, 7'b1000000, 6);
        hold(4'b1101, 7'b1111001, 6);
        hold(4'b1011, 7'b0100100, 6);
        hold(4'b0111, 7'b0110000, 6);
        hold(4'b1111, 7'h7F, 4);
        chk("scan_value", value, 16'h3210);
        chk("scan_vv_count", 16'(vv_cnt), 16'd1);

        // Held one cycle short of the threshold
        err_cnt = 0;
        vv_cnt = 0;
        hold(4'b1110, 7'b0010010, 3);
        hold(4'b1111, 7'h7F, 8);
        chk("short_seen", {12'd0, seen}, 16'h0000);
        chk("short_err", 16'(err_cnt), 16'd0);

        // Invalid pattern after two captures
        hold(4'b1110, 7'b1111000, 6);
        hold(4'b1101, 7'b0000000, 6);
        hold(4'b1111, 7'h7F, 3);
        chk("pre_err_seen", {12'd0, seen}, 16'h0003);
        err_cnt = 0;
        hold(4'b1011, 7'h7F, 5);
        hold(4'b1111, 7'h7F, 4);
        chk("err_count", 16'(err_cnt), 16'd1);
        chk("err_seen", {12'd0, seen}, 16'h0000);
        chk("err_value", value, 16'h3210);

        // Blanked / multi-select anodes
        err_cnt = 0;
        vv_cnt = 0;
        hold(4'b1100, 7'($urandom), 20);
        hold(4'b1111, 7'b1111001, 20);
        chk("blank_err", 16'(err_cnt), 16'd0);
        chk("blank_seen", {12'd0, seen}, 16'h0000);

        // Long hold decodes once
        hold(4'b1011, 7'b0011001, 50);
        hold(4'b1111, 7'h7F, 3);
        chk("long_seen", {12'd0, seen}, 16'h0004);

        // Table-driven vectors
        do_reset();
        foreach (tbl[i]) begin
            hold(tbl[i].an, tbl[i].seg, tbl[i].n);
            chk($sformatf("tbl%0d_seen", i), {12'd0, seen}, {12'd0, tbl[i].exp_seen});
            chk($sformatf("tbl%0d_value", i), value, tbl[i].exp_value);
        end

        // Reset mid-scan, then full scan 9,8,7,6 with latency check
        do_reset();
        hold(4'b1110, 7'b1111001, 6);
        hold(4'b1101, 7'b0100100, 6);
        hold(4'b1011, 7'b0110000, 6);
        hold(4'b1111, 7'h7F, 3);
        reset_n = 1'b0;
        #1;
        chk("async_reset_seen", {12'd0, seen}, 16'h0000);
        tick();
        tick();
        reset_n = 1'b1;
        vv_cnt = 0;
        hold(4'b1110, 7'b0010000, 6);
        hold(4'b1101, 7'b0000000, 6);
        hold(4'b1011, 7'b1111000, 6);
        start = cyc + 1;
        hold(4'b0111, 7'b0000010, 6);
        hold(4'b1111, 7'h7F, 6);
        chk("rst_scan_value", value, 16'h6789);
        chk("rst_scan_vv_count", 16'(vv_cnt), 16'd1);
        chk("latency", 16'(vv_cyc - start), 16'(S + 1 + D));

        // Random full scans with arithmetic expectation
        for (int r = 0; r < 5; r++) begin
            vv_cnt = 0;
            exp_v = 16'h0;
            for (int k = 0; k < 4; k++) begin
                dg[k] = 4'($urandom_range(0, 9));
                exp_v = exp_v | (16'(dg[k]) << (4 * k));
            end
            for (int k = 0; k < 4; k++)
                hold(~(4'b0001 << k), pats[dg[k]], $urandom_range(5, 7));
            hold(4'b1111, 7'h7F, 5);
            chk("rand_scan_value", value, exp_v);
            chk("rand_scan_vv", 16'(vv_cnt), 16'd1);
        end

        // Random pairs against the reference model
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 7) an = ~(4'b0001 << $urandom_range(0, 3));
            else an = 4'($urandom);
            if ($urandom_range(0, 5) != 0) sg = pats[$urandom_range(0, 9)];
            else sg = 7'($urandom);
            hold(an, sg, $urandom_range(1, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
